// File: rtl/wall_renderer_pkg.sv
// Shared geometry, colour and column-entry types
// for the wall renderer and its column store.
package wall_renderer_pkg;

  localparam int H_VIEW  = 640;
  localparam int V_VIEW  = 480;
  localparam int HORIZON = 240;
  localparam int COL_W   = 10;
  localparam int HGT_W   = 8;
  localparam int ADDR_W  = COL_W + 1;
  localparam int ENT_W   = HGT_W + 1;

  localparam logic [5:0] C_CEIL  = 6'b010101;
  localparam logic [5:0] C_FLOOR = 6'b101010;
  localparam logic [5:0] C_WALL0 = 6'b110000;
  localparam logic [5:0] C_WALL1 = 6'b100000;

  typedef struct packed {
    logic             side;
    logic [HGT_W-1:0] height;
  } col_t;

  // Distance of line v from the horizon; the line just
  // below the horizon counts as 1 so spans are 2H tall.
  function automatic logic [COL_W-1:0] span_dist(
    input logic [COL_W-1:0] v,
    input logic [COL_W-1:0] hz
  );
    if (v < hz) return hz - v;
    return v - hz + COL_W'(1);
  endfunction

endpackage

// File: rtl/column_ram.sv
// Simple dual-port column store: one write port and
// one registered read port, no reset on contents.
module column_ram #(
  parameter int DEPTH = 1280,
  parameter int AW    = 11,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wall_renderer.sv
// Double-buffered column store plus a 2-stage pipeline
// turning the scan position into a wall/ceiling/floor pixel.
module wall_renderer
  import wall_renderer_pkg::*;
#(
  parameter int         P_H_VIEW  = H_VIEW,
  parameter int         P_HORIZON = HORIZON,
  parameter logic [5:0] P_C_CEIL  = C_CEIL,
  parameter logic [5:0] P_C_FLOOR = C_FLOOR,
  parameter logic [5:0] P_C_WALL0 = C_WALL0,
  parameter logic [5:0] P_C_WALL1 = C_WALL1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             store,
  input  logic [COL_W-1:0] column,
  input  logic             side,
  input  logic [HGT_W-1:0] height,
  input  logic             frame_start,
  input  logic [COL_W-1:0] h,
  input  logic [COL_W-1:0] v,
  input  logic             visible,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [5:0]       rgb,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             wall
);

  localparam logic [COL_W-1:0] H_LIM =
    COL_W'(P_H_VIEW);
  localparam logic [COL_W-1:0] HZ =
    COL_W'(P_HORIZON);

  logic rd_bank, dirty, valid;
  logic wr_ok, swap, rd_sel;
  logic [ADDR_W-1:0] waddr, raddr;
  col_t wdata, rd;
  logic [COL_W-1:0] rcol;

  assign wr_ok  = store && (column < H_LIM);
  assign swap   = frame_start && dirty;
  // Read the bank that will be live after this edge so
  // the first pixel of a new frame is already from it.
  assign rd_sel = swap ? ~rd_bank : rd_bank;
  assign rcol   = (h < H_LIM) ? h : '0;
  assign waddr  = {~rd_bank, column};
  assign raddr  = {rd_sel, rcol};
  assign wdata  = '{side: side, height: height};

  column_ram #(
    .DEPTH (2 * P_H_VIEW),
    .AW    (ADDR_W),
    .DW    (ENT_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank <= 1'b0;
      dirty   <= 1'b0;
      valid   <= 1'b0;
    end else if (swap) begin
      rd_bank <= ~rd_bank;
      dirty   <= 1'b0;
      valid   <= 1'b1;
    end else if (wr_ok) begin
      dirty   <= 1'b1;
    end
  end

  logic [COL_W-1:0] v1;
  logic vis1, hs1, vs1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= '0;
      vis1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
    end else begin
      v1   <= v;
      vis1 <= visible;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
    end
  end

  logic [COL_W-1:0] d;
  logic             is_wall;
  logic [5:0]       pix;

  always_comb begin
    d       = span_dist(v1, HZ);
    is_wall = valid && vis1
           && (rd.height != '0)
           && (d <= {2'b00, rd.height});
    pix     = '0;
    unique case (1'b1)
      !vis1:   pix = '0;
      is_wall: pix = rd.side ? P_C_WALL1
                             : P_C_WALL0;
      default: pix = (v1 < HZ) ? P_C_CEIL
                               : P_C_FLOOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= '0;
      wall      <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb       <= pix;
      wall      <= is_wall;
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  end

endmodule

// File: tb/tb_wall_renderer.sv
// Directed bench for wall_renderer: bank swap, span
// edges, dropped writes, sync latency and reset.
module tb_wall_renderer;

  localparam logic [5:0] CE = 6'b010101;
  localparam logic [5:0] FL = 6'b101010;
  localparam logic [5:0] W0 = 6'b110000;
  localparam logic [5:0] W1 = 6'b100000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       store = 1'b0;
  logic [9:0] column = '0;
  logic       side = 1'b0;
  logic [7:0] height = '0;
  logic       frame_start = 1'b0;
  logic [9:0] h = '0;
  logic [9:0] v = '0;
  logic       visible = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out, wall;

  int total = 0;
  int bad = 0;

  wall_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .store       (store),
    .column      (column),
    .side        (side),
    .height      (height),
    .frame_start (frame_start),
    .h           (h),
    .v           (v),
    .visible     (visible),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .wall        (wall)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] c,
                    input logic s,
                    input logic [7:0] ht);
    store  = 1'b1;
    column = c;
    side   = s;
    height = ht;
    tick();
    store  = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    h = '0;
    v = '0;
    visible = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic probe(input string tag,
                       input logic [9:0] ph,
                       input logic [9:0] pv,
                       input logic pvis,
                       input logic [5:0] er,
                       input logic ew);
    h = ph;
    v = pv;
    visible = pvis;
    tick();
    tick();
    check({tag, ".rgb"}, 16'(rgb), 16'(er));
    check({tag, ".wall"}, 16'(wall), 16'(ew));
  endtask

  task automatic zero_cols();
    wr(0, 0, 0);
    wr(5, 0, 0);
    wr(7, 0, 0);
    wr(10, 0, 0);
    wr(639, 0, 0);
  endtask

  initial begin
    visible = 1'b1;
    repeat (3) tick();
    check("rst.rgb", 16'(rgb), 16'h0);
    check("rst.wall", 16'(wall), 16'h0);
    check("rst.hs", 16'(hsync_out), 16'h0);
    check("rst.vs", 16'(vsync_out), 16'h0);
    reset = 1'b0;

    probe("t1.v0", 10, 0, 1, CE, 0);
    probe("t1.v239", 10, 239, 1, CE, 0);
    probe("t1.v240", 10, 240, 1, FL, 0);
    probe("t1.v479", 639, 479, 1, FL, 0);
    probe("t1.invis", 100, 100, 0, 6'h0, 0);
    probe("t1.hblank", 700, 300, 0, 6'h0, 0);

    zero_cols();
    fs();
    zero_cols();
    fs();
    probe("init", 10, 200, 1, CE, 0);

    wr(10, 0, 100);
    fs();
    probe("t2.v140", 10, 140, 1, W0, 1);
    probe("t2.v240", 10, 240, 1, W0, 1);
    probe("t2.v339", 10, 339, 1, W0, 1);
    probe("t2.v139", 10, 139, 1, CE, 0);
    probe("t2.v340", 10, 340, 1, FL, 0);

    wr(639, 1, 240);
    wr(640, 0, 50);
    fs();
    probe("t3.v0", 639, 0, 1, W1, 1);
    probe("t3.v479", 639, 479, 1, W1, 1);
    probe("t3.c0", 0, 240, 1, FL, 0);
    wr(640, 1, 200);
    fs();
    probe("t3.noswap", 639, 0, 1, W1, 1);
    probe("t3.c0b", 0, 230, 1, CE, 0);

    wr(5, 0, 20);
    fs();
    probe("t4.v220", 5, 220, 1, W0, 1);
    probe("t4.v219", 5, 219, 1, CE, 0);
    probe("t4.v259", 5, 259, 1, W0, 1);
    probe("t4.v260", 5, 260, 1, FL, 0);
    fs();
    probe("t4.reshow", 5, 220, 1, W0, 1);
    wr(5, 1, 200);
    probe("t4.live", 5, 100, 1, CE, 0);
    probe("t4.live2", 5, 220, 1, W0, 1);

    frame_start = 1'b1;
    store = 1'b1;
    column = 7;
    side = 1'b0;
    height = 60;
    h = '0;
    v = '0;
    tick();
    frame_start = 1'b0;
    store = 1'b0;
    probe("t5.v180", 7, 180, 1, W0, 1);
    probe("t5.v179", 7, 179, 1, CE, 0);
    probe("t5.v299", 7, 299, 1, W0, 1);
    probe("t5.v300", 7, 300, 1, FL, 0);
    probe("t5.c5", 5, 100, 1, W1, 1);
    fs();
    probe("t5.clean", 7, 180, 1, W0, 1);

    hsync_in = 1'b1;
    tick();
    check("t6.hs1", 16'(hsync_out), 16'h0);
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    tick();
    check("t6.hs2", 16'(hsync_out), 16'h1);
    check("t6.vs1", 16'(vsync_out), 16'h0);
    vsync_in = 1'b0;
    tick();
    check("t6.hs3", 16'(hsync_out), 16'h0);
    check("t6.vs2", 16'(vsync_out), 16'h1);
    tick();
    check("t6.vs3", 16'(vsync_out), 16'h0);

    h = 7;
    v = 180;
    visible = 1'b1;
    tick();
    tick();
    check("t6.pre", 16'(rgb), 16'(W0));
    reset = 1'b1;
    tick();
    check("t6.rst.rgb", 16'(rgb), 16'h0);
    check("t6.rst.wall", 16'(wall), 16'h0);
    reset = 1'b0;
    probe("t6.after", 7, 180, 1, CE, 0);
    fs();
    probe("t6.noswap", 7, 180, 1, CE, 0);
    wr(7, 1, 60);
    fs();
    probe("t6.swap", 7, 180, 1, W1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
